// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between the edge-event arbiter and its consumer.
//   evt_valid : event present on evt_chan/evt_rise (driven by master)
//   evt_chan  : channel index of the presented event (driven by master)
//   evt_rise  : 1 = rising edge, 0 = falling edge (driven by master)
//   evt_ready : consumer accepts the presented event (driven by slave)
interface edge_event_arbiter_if #(
    parameter int N = 4
);
    localparam int IW = $clog2(N);

    logic          evt_valid;
    logic [IW-1:0] evt_chan;
    logic          evt_rise;
    logic          evt_ready;

    modport master (
        output evt_valid,
        output evt_chan,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_chan,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler. A dual-edge detector on each
// synchronized input latches one pending event per channel; a round-robin
// arbiter presents pending events one at a time on a valid/ready port.
//   clk     : clock, all state on rising edge
//   rst     : asynchronous active-high reset
//   sig     : per-channel level inputs (already synchronized)
//   en      : per-channel enable; 0 flushes that channel's pending event
//   ovf_clr : synchronous clear of ovf_cnt
//   pending : registered per-channel pending flags
//   ovf_cnt : saturating count of cycles in which an event was dropped
//   evt     : event handshake (master side)
module edge_event_arbiter #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         sig,
    input  logic [N-1:0]         en,
    input  logic                 ovf_clr,
    output logic [N-1:0]         pending,
    output logic [CW-1:0]        ovf_cnt,
    edge_event_arbiter_if.master evt
);
    localparam int IW = $clog2(N);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    logic [N-1:0]  cur_q, prev_q;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  ptype_q, ptype_d;
    logic [0:0]    state_q, state_d;
    logic [IW-1:0] chan_q, chan_d;
    logic          rise_q, rise_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] ovf_q, ovf_d;

    logic [N-1:0]  edge_det;
    logic [N-1:0]  consume;
    logic [N-1:0]  drop_vec;
    logic          any_pend;
    logic          take;
    logic [IW-1:0] win;
    int unsigned   idx;

    assign edge_det = cur_q ^ prev_q;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        any_pend = 1'b0;
        win      = '0;
        idx      = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!any_pend && pend_q[IW'(idx)]) begin
                any_pend = 1'b1;
                win      = IW'(idx);
            end
        end
    end

    // The output register can accept a new winner when empty or being drained.
    assign take    = any_pend && ((state_q == S_IDLE) || evt.evt_ready);
    assign consume = take ? (N'(1) << win) : '0;

    // A channel whose stored event is being granted this cycle may capture a
    // fresh edge in the same cycle; otherwise a second edge is dropped.
    always_comb begin
        pend_d   = pend_q;
        ptype_d  = ptype_q;
        drop_vec = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!en[i]) begin
                pend_d[i] = 1'b0;
            end else if (edge_det[i] && (!pend_q[i] || consume[i])) begin
                pend_d[i]  = 1'b1;
                ptype_d[i] = cur_q[i];
            end else if (edge_det[i]) begin
                drop_vec[i] = 1'b1;
            end else if (consume[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        rise_d  = rise_q;
        ptr_d   = ptr_q;
        if (take) begin
            state_d = S_PRESENT;
            chan_d  = win;
            rise_d  = ptype_q[win];
            ptr_d   = win;
        end else if ((state_q == S_PRESENT) && evt.evt_ready) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = (|drop_vec) ? CW'(1) : '0;
        end else if ((|drop_vec) && (ovf_q != '1)) begin
            ovf_d = ovf_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q   <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            state_q <= S_IDLE;
            chan_q  <= '0;
            rise_q  <= 1'b0;
            ptr_q   <= IW'(N - 1);
            ovf_q   <= '0;
        end else begin
            cur_q   <= sig;
            prev_q  <= cur_q;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            state_q <= state_d;
            chan_q  <= chan_d;
            rise_q  <= rise_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt.evt_valid = (state_q == S_PRESENT);
    assign evt.evt_chan  = chan_q;
    assign evt.evt_rise  = rise_q;
    assign pending       = pend_q;
    assign ovf_cnt       = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against an event-level reference model. A second
// instance with a 2-bit overflow counter shares the same stimulus.
module tb_edge_event_arbiter;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] sig;
    logic [N-1:0] en;
    logic         clr;
    logic         rdy;
    logic [N-1:0] pend1, pend2;
    logic [7:0]   ovf1;
    logic [1:0]   ovf2;

    edge_event_arbiter_if #(.N(N)) evt_if ();
    edge_event_arbiter_if #(.N(N)) evt_if2 ();

    assign evt_if.evt_ready  = rdy;
    assign evt_if2.evt_ready = rdy;

    edge_event_arbiter #(.N(N), .CW(8)) dut (
        .clk(clk), .rst(rst), .sig(sig), .en(en), .ovf_clr(clr),
        .pending(pend1), .ovf_cnt(ovf1), .evt(evt_if)
    );

    edge_event_arbiter #(.N(N), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .sig(sig), .en(en), .ovf_clr(clr),
        .pending(pend2), .ovf_cnt(ovf2), .evt(evt_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sampled-level history, one stored event per channel,
    // one output slot, the last granted channel, and a raw drop-cycle count.
    typedef struct {
        bit valid;
        bit rise;
    } ev_t;

    bit [N-1:0] m_last;   // level seen at the most recent edge
    bit [N-1:0] m_older;  // level seen one edge earlier
    ev_t        m_store[N];
    ev_t        m_out;
    int         m_chan;
    int         m_last_grant;
    int         m_drops;

    function automatic void model_reset();
        m_last  = '0;
        m_older = '0;
        for (int i = 0; i < N; i++) m_store[i] = '{0, 0};
        m_out        = '{0, 0};
        m_chan       = 0;
        m_last_grant = N - 1;
        m_drops      = 0;
    endfunction

    function automatic void model_tick();
        int  winner;
        bit  grant;
        bit  dropped;
        ev_t nxt[N];
        winner = -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last_grant + k) % N;
            if (winner < 0 && m_store[c].valid) winner = c;
        end
        grant   = (winner >= 0) && (!m_out.valid || rdy);
        dropped = 0;
        for (int i = 0; i < N; i++) begin
            bit new_ev;
            bit freed;
            new_ev = (m_last[i] != m_older[i]);
            freed  = grant && (winner == i);
            nxt[i] = m_store[i];
            if (freed) nxt[i].valid = 0;
            if (en[i] == 1'b0) nxt[i].valid = 0;
            else if (new_ev) begin
                if (nxt[i].valid) dropped = 1;
                else nxt[i] = '{1, m_last[i]};
            end
        end
        if (grant) begin
            m_out        = '{1, m_store[winner].rise};
            m_chan       = winner;
            m_last_grant = winner;
        end else if (m_out.valid && rdy) begin
            m_out.valid = 0;
        end
        for (int i = 0; i < N; i++) m_store[i] = nxt[i];
        if (clr) m_drops = dropped ? 1 : 0;
        else     m_drops = m_drops + (dropped ? 1 : 0);
        m_older = m_last;
        m_last  = sig;
    endfunction

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_store[i].valid;
        return p;
    endfunction

    task automatic compare_all();
        int sat8, sat2;
        sat8 = (m_drops > 255) ? 255 : m_drops;
        sat2 = (m_drops > 3) ? 3 : m_drops;
        chk("valid",   evt_if.evt_valid, m_out.valid);
        chk("chan",    evt_if.evt_chan, m_chan);
        chk("rise",    evt_if.evt_rise, m_out.rise);
        chk("pending", pend1, model_pending());
        chk("ovf",     ovf1, sat8);
        chk("valid2",  evt_if2.evt_valid, m_out.valid);
        chk("chan2",   evt_if2.evt_chan, m_chan);
        chk("pending2", pend2, model_pending());
        chk("ovf2",    ovf2, sat2);
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sig = '0;
        clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen2;
        rst = 1'b1;
        sig = '0;
        en  = '1;
        clr = 1'b0;
        rdy = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_pend",  pend1, 0);
        chk("rst_ovf",   ovf1, 0);

        // 1: single rising edge latency
        apply_reset();
        sig = 4'b0001;
        step();
        step();
        chk("t1_pend", pend1, 4'b0001);
        step();
        chk("t1_valid", evt_if.evt_valid, 1);
        chk("t1_chan",  evt_if.evt_chan, 0);
        chk("t1_rise",  evt_if.evt_rise, 1);
        step();
        chk("t1_idle", evt_if.evt_valid, 0);

        // 2: simultaneous edges, round-robin order
        apply_reset();
        rdy = 1'b1;
        sig = 4'b1111;
        step();
        step();
        for (int k = 0; k < N; k++) begin
            step();
            chk("t2_rvalid", evt_if.evt_valid, 1);
            chk("t2_rchan",  evt_if.evt_chan, k);
            chk("t2_rrise",  evt_if.evt_rise, 1);
        end
        sig = 4'b0000;
        step();
        step();
        for (int k = 0; k < N; k++) begin
            step();
            chk("t2_fchan", evt_if.evt_chan, k);
            chk("t2_frise", evt_if.evt_rise, 0);
        end
        sig = 4'b0110;
        repeat (8) step();
        for (int r = 0; r < 6; r++) begin
            sig = sig ^ 4'b0110;
            step();
            step();
        end
        repeat (4) step();

        // 3: backpressure holds the presented event
        apply_reset();
        rdy = 1'b0;
        sig = 4'b0010;
        step();
        step();
        step();
        sig = 4'b0000;
        step();
        step();
        step();
        chk("t3_valid", evt_if.evt_valid, 1);
        chk("t3_chan",  evt_if.evt_chan, 1);
        chk("t3_rise",  evt_if.evt_rise, 1);
        chk("t3_pend",  pend1, 4'b0010);
        chk("t3_ovf",   ovf1, 0);
        rdy = 1'b1;
        step();
        chk("t3_nchan", evt_if.evt_chan, 1);
        chk("t3_nrise", evt_if.evt_rise, 0);
        repeat (3) step();

        // 4: overflow counting, clear, saturation
        apply_reset();
        rdy = 1'b0;
        for (int r = 0; r < 5; r++) begin
            sig[3] = ~sig[3];
            step();
            step();
        end
        step();
        chk("t4_ovf", ovf1, 3);
        sig[3] = ~sig[3];
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_clr", ovf1, 1);
        for (int r = 0; r < 5; r++) begin
            sig[3] = ~sig[3];
            step();
            step();
        end
        chk("t4_ovf8", ovf1, 6);
        chk("t4_sat2", ovf2, 3);
        rdy = 1'b1;
        repeat (4) step();

        // 5: disable flushes pending and suppresses new events
        apply_reset();
        rdy = 1'b0;
        sig = 4'b0001;
        repeat (3) step();
        sig = 4'b0101;
        step();
        step();
        chk("t5_pend", pend1, 4'b0100);
        en = 4'b1011;
        step();
        chk("t5_flush", pend1, 4'b0000);
        sig[2] = 1'b0;
        step();
        step();
        sig[2] = 1'b1;
        step();
        step();
        rdy   = 1'b1;
        seen2 = 0;
        for (int r = 0; r < 6; r++) begin
            step();
            if (evt_if.evt_valid && evt_if.evt_chan == 2) seen2++;
        end
        chk("t5_no_ch2", seen2, 0);
        en = '1;
        repeat (3) step();

        // 6: asynchronous reset mid-handshake
        apply_reset();
        rdy = 1'b0;
        sig = 4'b0001;
        repeat (3) step();
        sig = 4'b0111;
        step();
        step();
        chk("t6_pend", pend1, 4'b0110);
        rst = 1'b1;
        #1;
        chk("t6_valid", evt_if.evt_valid, 0);
        chk("t6_pendz", pend1, 0);
        chk("t6_ovf",   ovf1, 0);
        sig = 4'b0110;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) step();
        chk("t6_first", evt_if.evt_chan, 1);
        chk("t6_fvalid", evt_if.evt_valid, 1);
        rdy = 1'b1;
        repeat (4) step();

        // Randomized traffic
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) sig[i] = ~sig[i];
                en[i] = ($urandom_range(0, 9) != 0);
            end
            rdy = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 19) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
